// File: rtl/xor16_parity_arbiter.sv
// xor16_parity_arbiter: round-robin sharing of one XOR16 parity unit among NREQ packet streams.
// Define XOR16_PARITY_ARB_BEATCNT_EN to add the per-packet beat count output O_BEATS.
module xor16_parity_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               CLK,
    input  logic               SRST,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ-1:0]    REQ_LAST,
    input  logic [16*NREQ-1:0] REQ_DATA,
    output logic [NREQ-1:0]    REQ_READY,
    output logic               O_VALID,
    output logic [IDW-1:0]     O_ID,
    output logic               O_PARITY,
`ifdef XOR16_PARITY_ARB_BEATCNT_EN
    output logic [7:0]         O_BEATS,
`endif
    input  logic               O_READY
);
    logic [IDW-1:0]  ptr_q, ptr_d, gidx, idx;
    logic [NREQ-1:0] acc_q, acc_d, grant;
    logic            ov_q, ov_d, par_q, par_d, take, slot_free, last, p;
    logic [IDW-1:0]  id_q, id_d;
    logic [15:0]     beat;

    assign slot_free = !ov_q || O_READY;
    assign REQ_READY = grant;
    assign O_VALID   = ov_q;
    assign O_ID      = id_q;
    assign O_PARITY  = par_q;

    // First valid requester at or after ptr, wrapping; blocked by reset or a stalled result.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        take  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!take && REQ_VALID[idx]) begin
                take        = 1'b1;
                grant[idx]  = 1'b1;
                gidx        = idx;
            end
        end
        if (SRST || !slot_free) begin
            grant = '0;
            take  = 1'b0;
        end
    end

    always_comb begin
        beat = '0;
        last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                beat = REQ_DATA[16*i +: 16];
                last = REQ_LAST[i];
            end
        end
        p = ^beat;
    end

    always_comb begin
        ptr_d = ptr_q;
        acc_d = acc_q;
        ov_d  = ov_q && !O_READY;
        id_d  = id_q;
        par_d = par_q;
        if (take) begin
            ptr_d = (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            acc_d[gidx] = last ? 1'b0 : acc_q[gidx] ^ p;
            if (last) begin
                ov_d  = 1'b1;
                id_d  = gidx;
                par_d = acc_q[gidx] ^ p;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            ptr_q <= '0;
            acc_q <= '0;
            ov_q  <= 1'b0;
            id_q  <= '0;
            par_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            acc_q <= acc_d;
            ov_q  <= ov_d;
            id_q  <= id_d;
            par_q <= par_d;
        end
    end

`ifdef XOR16_PARITY_ARB_BEATCNT_EN
    logic [7:0] cnt_q [NREQ];
    logic [7:0] cnt_d [NREQ];
    logic [7:0] beats_q, beats_d, cnt_inc;

    assign O_BEATS = beats_q;

    always_comb begin
        cnt_d   = cnt_q;
        beats_d = beats_q;
        cnt_inc = (cnt_q[gidx] == 8'hFF) ? 8'hFF : cnt_q[gidx] + 8'd1;
        if (take) begin
            cnt_d[gidx] = last ? 8'd0 : cnt_inc;
            beats_d     = last ? cnt_inc : beats_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            cnt_q   <= '{default: '0};
            beats_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
        end
    end
`endif
endmodule

// File: tb/tb_xor16_parity_arbiter.sv
// tb_xor16_parity_arbiter: directed vector table, corner sequences and random run against a reference model.
module tb_xor16_parity_arbiter;
    logic        CLK = 1'b0;
    logic        SRST = 1'b1;
    logic [3:0]  REQ_VALID = '0, REQ_LAST = '0, REQ_READY;
    logic [63:0] REQ_DATA = '0;
    logic        O_VALID, O_PARITY, O_READY = 1'b1;
    logic [1:0]  O_ID;
`ifdef XOR16_PARITY_ARB_BEATCNT_EN
    logic [7:0]  O_BEATS;
`endif

    always #5 CLK = ~CLK;

    xor16_parity_arbiter #(.NREQ(4), .IDW(2)) dut (
        .CLK(CLK), .SRST(SRST), .REQ_VALID(REQ_VALID), .REQ_LAST(REQ_LAST),
        .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .O_VALID(O_VALID),
        .O_ID(O_ID), .O_PARITY(O_PARITY),
`ifdef XOR16_PARITY_ARB_BEATCNT_EN
        .O_BEATS(O_BEATS),
`endif
        .O_READY(O_READY)
    );

    typedef struct {
        logic [3:0]  v, l;
        logic [63:0] d;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  id;
        logic        par;
        logic [7:0]  beats;
    } vec_t;

    int total = 0, bad = 0;
    logic [3:0] rdy_s;
    vec_t tbl[16];

    // Reference model: ones counted per packet, parity taken at the end.
    int m_ptr, m_id, m_beats;
    int m_ones[4], m_cnt[4];
    bit m_ov, m_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] v, input logic [3:0] l,
                        input logic [63:0] d, input logic ordy);
        @(negedge CLK);
        SRST = rst; REQ_VALID = v; REQ_LAST = l; REQ_DATA = d; O_READY = ordy;
        #1 rdy_s = REQ_READY;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] mgrant(input logic rst, input logic [3:0] v, input logic ordy);
        if (rst || (m_ov && !ordy)) return 4'b0;
        for (int k = 0; k < 4; k++) begin
            int i = (m_ptr + k) % 4;
            if (v[i]) return 4'(1 << i);
        end
        return 4'b0;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_id = 0; m_beats = 0; m_ov = 0; m_par = 0;
        for (int i = 0; i < 4; i++) begin m_ones[i] = 0; m_cnt[i] = 0; end
    endtask

    task automatic model_edge(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [63:0] d, input logic ordy);
        logic [3:0] gr;
        int g;
        gr = mgrant(rst, v, ordy);
        g = -1;
        if (rst) begin model_reset(); return; end
        for (int i = 0; i < 4; i++) if (gr[i]) g = i;
        if (g < 0) begin
            if (ordy) m_ov = 0;
            return;
        end
        m_ones[g] += $countones(d[16*g +: 16]);
        m_cnt[g] = (m_cnt[g] >= 255) ? 255 : m_cnt[g] + 1;
        if (l[g]) begin
            m_ov = 1; m_id = g; m_par = m_ones[g] % 2; m_beats = m_cnt[g];
            m_ones[g] = 0; m_cnt[g] = 0;
        end else if (ordy) m_ov = 0;
        m_ptr = (g + 1) % 4;
    endtask

    initial begin
        logic [63:0] dd;
        dd = 64'h000F_0007_0003_0001;
        tbl[0]  = '{4'b0010, 4'b0010, 64'h0000_0000_0001_0000, 1, 4'b0010, 1, 1, 1, 1};
        tbl[1]  = '{4'b0100, 4'b0100, 64'h0000_FFFF_0000_0000, 1, 4'b0100, 1, 2, 0, 1};
        tbl[2]  = '{4'b0001, 4'b0000, 64'h3,    1, 4'b0001, 0, 0, 0, 0};
        tbl[3]  = '{4'b0001, 4'b0000, 64'h0100, 1, 4'b0001, 0, 0, 0, 0};
        tbl[4]  = '{4'b0001, 4'b0001, 64'h8000, 1, 4'b0001, 1, 0, 0, 3};
        tbl[5]  = '{4'b1111, 4'b1111, dd, 0, 4'b0000, 1, 0, 0, 3};
        tbl[6]  = '{4'b1111, 4'b1111, dd, 0, 4'b0000, 1, 0, 0, 3};
        tbl[7]  = '{4'b1111, 4'b1111, dd, 1, 4'b0010, 1, 1, 0, 1};
        tbl[8]  = '{4'b1111, 4'b1111, dd, 1, 4'b0100, 1, 2, 1, 1};
        tbl[9]  = '{4'b1111, 4'b1111, dd, 1, 4'b1000, 1, 3, 0, 1};
        tbl[10] = '{4'b1111, 4'b1111, dd, 1, 4'b0001, 1, 0, 1, 1};
        tbl[11] = '{4'b1111, 4'b1111, dd, 1, 4'b0010, 1, 1, 0, 1};
        tbl[12] = '{4'b0000, 4'b0000, 64'h0, 1, 4'b0000, 0, 0, 0, 0};
        tbl[13] = '{4'b0011, 4'b0011, 64'h0000_0000_0001_0001, 1, 4'b0001, 1, 0, 1, 1};
        tbl[14] = '{4'b0010, 4'b0000, 64'h0000_0000_0001_0000, 1, 4'b0010, 0, 0, 0, 0};
        tbl[15] = '{4'b0010, 4'b0010, 64'h0, 1, 4'b0010, 1, 1, 1, 2};

        for (int c = 0; c < 3; c++) begin
            step(1, 4'hF, 4'h0, 64'h0, 1);
            chk("reset_ready", rdy_s, 0);
            chk("reset_ovalid", O_VALID, 0);
        end
        chk("reset_id", O_ID, 0);
        chk("reset_parity", O_PARITY, 0);
        step(0, 4'hF, 4'h0, 64'h0, 1);
        chk("first_grant", rdy_s, 4'b0001);
        step(1, 4'h0, 4'h0, 64'h0, 1);

        for (int i = 0; i < 16; i++) begin
            step(0, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d_ready", i), rdy_s, tbl[i].rdy);
            chk($sformatf("vec%0d_ovalid", i), O_VALID, tbl[i].ov);
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_id", i), O_ID, tbl[i].id);
                chk($sformatf("vec%0d_parity", i), O_PARITY, tbl[i].par);
`ifdef XOR16_PARITY_ARB_BEATCNT_EN
                chk($sformatf("vec%0d_beats", i), O_BEATS, tbl[i].beats);
`endif
            end
        end

        step(0, 4'b0001, 4'b0000, 64'h1, 1);
        step(0, 4'b1000, 4'b0000, 64'h0007_0000_0000_0000, 1);
        step(1, 4'b1111, 4'b0000, 64'h0, 1);
        chk("midrst_ready", rdy_s, 0);
        chk("midrst_ovalid", O_VALID, 0);
        step(0, 4'b0001, 4'b0001, 64'h0, 1);
        chk("midrst_grant", rdy_s, 4'b0001);
        chk("midrst_ovalid2", O_VALID, 1);
        chk("midrst_id", O_ID, 0);
        chk("midrst_parity", O_PARITY, 0);
`ifdef XOR16_PARITY_ARB_BEATCNT_EN
        chk("midrst_beats", O_BEATS, 1);
`endif

        step(1, 4'h0, 4'h0, 64'h0, 1);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] v, l, eg;
            logic [63:0] d;
            logic ordy, rst;
            v = 4'($urandom); l = 4'($urandom);
            d = {$urandom, $urandom};
            ordy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            eg = mgrant(rst, v, ordy);
            step(rst, v, l, d, ordy);
            model_edge(rst, v, l, d, ordy);
            chk("rand_ready", rdy_s, eg);
            chk("rand_ovalid", O_VALID, m_ov);
            if (m_ov) begin
                chk("rand_id", O_ID, m_id);
                chk("rand_parity", O_PARITY, m_par);
`ifdef XOR16_PARITY_ARB_BEATCNT_EN
                chk("rand_beats", O_BEATS, m_beats);
`endif
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
